// File: rtl/ram_pkg.sv
// Shared definitions for the simple-dual-port RAM: collision modes,
// clear-sweep states and the byte-lane merge helper.
package ram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    IDLE = 1'b0,
    CLR  = 1'b1
  } clr_state_e;

  // One byte lane of a masked merge: the new byte wins where its enable is set.
  function automatic logic [7:0] merge_lane(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/ram_sdp_core.sv
// Bare byte-maskable array with one write port and one registered read port;
// same-address collisions return either the old or the merged word.
module ram_sdp_core
  import ram_pkg::*;
#(
  parameter int CAddrLen  = 13,
  parameter int CDataLen  = 128,
  parameter int CRdWrMode = RDW_OLD
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  wr_en_i,
  input  logic [CAddrLen-1:0]   wr_addr_i,
  input  logic [CDataLen-1:0]   wr_data_i,
  input  logic [CDataLen/8-1:0] wr_mask_i,
  input  logic                  rd_en_i,
  input  logic [CAddrLen-1:0]   rd_addr_i,
  output logic [CDataLen-1:0]   rd_data_o
);

  localparam int  Lanes      = CDataLen / 8;
  localparam int  Depth      = 2 ** CAddrLen;
  localparam bit  WrThrough  = (CRdWrMode == RDW_NEW);

  logic [Lanes-1:0][7:0] mem_q [Depth];
  logic [Lanes-1:0][7:0] wr_lanes;
  logic [Lanes-1:0][7:0] rd_data_q;
  logic                  collide;

  assign wr_lanes  = wr_data_i;
  assign collide   = wr_en_i && (wr_addr_i == rd_addr_i);
  assign rd_data_o = rd_data_q;

  // Read samples the array before this edge's write lands, so old-data
  // behaviour falls out naturally; write-through patches in the written lanes.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int i = 0; i < Lanes; i++) begin
        if (wr_en_i && wr_mask_i[i]) begin
          mem_q[wr_addr_i][i] <= wr_lanes[i];
        end
      end
      if (rd_en_i) begin
        for (int i = 0; i < Lanes; i++) begin
          rd_data_q[i] <= merge_lane(mem_q[rd_addr_i][i], wr_lanes[i],
                                     WrThrough && collide && wr_mask_i[i]);
        end
      end
    end
  end

endmodule

// File: rtl/ram_sdp_bx.sv
// Simple-dual-port RAM with byte masks, 1- or 2-clock read latency, read-valid
// flag and an optional zeroing sweep after reset.
module ram_sdp_bx
  import ram_pkg::*;
#(
  parameter int CAddrLen    = 13,
  parameter int CDataLen    = 128,
  parameter int CRdLat      = 1,
  parameter int CRdWrMode   = RDW_OLD,
  parameter int CClrOnReset = 1
) (
  input  logic                  AClkH,
  input  logic                  AResetHN,
  input  logic                  AClkHEn,
  input  logic [CAddrLen-1:0]   AAddrWr,
  input  logic [CDataLen-1:0]   AMosi,
  input  logic [CDataLen/8-1:0] AWrMask,
  input  logic                  AWrEn,
  input  logic [CAddrLen-1:0]   AAddrRd,
  input  logic                  ARdEn,
  output logic [CDataLen-1:0]   AMiso,
  output logic                  ARdVld,
  output logic                  ABusy
);

  if ((CDataLen % 8) != 0 || (CRdLat != 1 && CRdLat != 2) ||
      (CRdWrMode != RDW_OLD && CRdWrMode != RDW_NEW)) begin : g_param_check
    $fatal(1, "ram_sdp_bx: illegal CDataLen, CRdLat or CRdWrMode");
  end

  clr_state_e            state_q, state_d;
  logic [CAddrLen-1:0]   clr_cnt_q, clr_cnt_d;
  logic                  busy;

  logic                  core_wr_en;
  logic [CAddrLen-1:0]   core_wr_addr;
  logic [CDataLen-1:0]   core_wr_data;
  logic [CDataLen/8-1:0] core_wr_mask;
  logic                  core_rd_en;
  logic [CDataLen-1:0]   core_rd_data;

  logic                  vld1_q;
  logic [CDataLen-1:0]   out_data;
  logic                  out_vld;

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      state_q   <= (CClrOnReset != 0) ? CLR : IDLE;
      clr_cnt_q <= '0;
    end else if (AClkHEn) begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy      = 1'b0;
    case (state_q)
      CLR: begin
        busy      = 1'b1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (&clr_cnt_q) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase
  end

  assign ABusy = busy;

  // During the sweep the write port is stolen for zero writes; user strobes are dropped.
  assign core_wr_en   = busy ? 1'b1      : AWrEn;
  assign core_wr_addr = busy ? clr_cnt_q : AAddrWr;
  assign core_wr_data = busy ? '0        : AMosi;
  assign core_wr_mask = busy ? '1        : AWrMask;
  assign core_rd_en   = ARdEn && !busy;

  ram_sdp_core #(
    .CAddrLen  (CAddrLen),
    .CDataLen  (CDataLen),
    .CRdWrMode (CRdWrMode)
  ) u_core (
    .clk_i     (AClkH),
    .en_i      (AClkHEn),
    .wr_en_i   (core_wr_en),
    .wr_addr_i (core_wr_addr),
    .wr_data_i (core_wr_data),
    .wr_mask_i (core_wr_mask),
    .rd_en_i   (core_rd_en),
    .rd_addr_i (AAddrRd),
    .rd_data_o (core_rd_data)
  );

  always_ff @(posedge AClkH or negedge AResetHN) begin
    if (!AResetHN) begin
      vld1_q <= 1'b0;
    end else if (AClkHEn) begin
      vld1_q <= core_rd_en;
    end
  end

  if (CRdLat == 2) begin : g_lat2
    logic [CDataLen-1:0] data2_q;
    logic                vld2_q;

    always_ff @(posedge AClkH or negedge AResetHN) begin
      if (!AResetHN) begin
        data2_q <= '0;
        vld2_q  <= 1'b0;
      end else if (AClkHEn) begin
        data2_q <= core_rd_data;
        vld2_q  <= vld1_q;
      end
    end

    assign out_data = data2_q;
    assign out_vld  = vld2_q;
  end else begin : g_lat1
    assign out_data = core_rd_data;
    assign out_vld  = vld1_q;
  end

  assign AMiso  = out_vld ? out_data : '0;
  assign ARdVld = out_vld;

endmodule

// File: tb/tb_ram_sdp_bx.sv
// Directed bench: two RAMs share stimulus, one with 1-clock latency / old-data
// collisions, the other with 2-clock latency / write-through collisions.
module tb_ram_sdp_bx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic        wr_en;
  logic [3:0]  rd_addr;
  logic        rd_en;
  logic [31:0] miso_a, miso_b;
  logic        vld_a, vld_b, busy_a, busy_b;

  int vec_cnt = 0;
  int err_cnt = 0;
  int done_a, done_b;

  always #5 clk = ~clk;

  ram_sdp_bx #(.CAddrLen(4), .CDataLen(32), .CRdLat(1), .CRdWrMode(0), .CClrOnReset(1)) dut_a (
    .AClkH(clk), .AResetHN(rst_n), .AClkHEn(en), .AAddrWr(wr_addr), .AMosi(wr_data),
    .AWrMask(wr_mask), .AWrEn(wr_en), .AAddrRd(rd_addr), .ARdEn(rd_en),
    .AMiso(miso_a), .ARdVld(vld_a), .ABusy(busy_a));

  ram_sdp_bx #(.CAddrLen(4), .CDataLen(32), .CRdLat(2), .CRdWrMode(1), .CClrOnReset(1)) dut_b (
    .AClkH(clk), .AResetHN(rst_n), .AClkHEn(en), .AAddrWr(wr_addr), .AMosi(wr_data),
    .AWrMask(wr_mask), .AWrEn(wr_en), .AAddrRd(rd_addr), .ARdEn(rd_en),
    .AMiso(miso_b), .ARdVld(vld_b), .ABusy(busy_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_sweep();
    done_a = 0;
    done_b = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      chk("busy_vld_a", {31'd0, vld_a}, 32'd0);
      chk("busy_vld_b", {31'd0, vld_b}, 32'd0);
      if (!busy_a && done_a == 0) done_a = n;
      if (!busy_b && done_b == 0) done_b = n;
      if (done_a != 0 && done_b != 0) break;
    end
    chk("clr_len_a", done_a, 32'd16);
    chk("clr_len_b", done_b, 32'd16);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_mask = '0;
    step(); step();
    $display("txn: reset held");
    chk("rst_busy_a", {31'd0, busy_a}, 32'd1);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd1);
    chk("rst_vld_a", {31'd0, vld_a}, 32'd0);
    chk("rst_miso_b", miso_b, 32'd0);

    rst_n = 1'b1;
    $display("txn: clear sweep after reset");
    count_sweep();

    $display("txn: read back all 16 words after clear");
    for (int i = 0; i <= 16; i++) begin
      rd_en = (i < 16);
      rd_addr = 4'(i);
      step();
      if (i < 16) begin
        chk("clr_rd_a", miso_a, 32'd0);
        chk("clr_vld_a", {31'd0, vld_a}, 32'd1);
      end else begin
        chk("clr_vld_a_end", {31'd0, vld_a}, 32'd0);
      end
      if (i >= 1) begin
        chk("clr_rd_b", miso_b, 32'd0);
        chk("clr_vld_b", {31'd0, vld_b}, 32'd1);
      end else begin
        chk("clr_vld_b_lat", {31'd0, vld_b}, 32'd0);
      end
    end
    step();
    chk("clr_vld_b_end", {31'd0, vld_b}, 32'd0);

    $display("txn: masked writes to addr 5");
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h11223344; wr_mask = 4'hF;
    step();
    wr_data = 32'hAABBCCDD; wr_mask = 4'h5;
    step();
    wr_en = 1'b0;
    rd_en = 1'b1; rd_addr = 4'd5;
    step();
    rd_en = 1'b0;
    chk("mask_rd_a", miso_a, 32'h11BB33DD);
    chk("mask_vld_a", {31'd0, vld_a}, 32'd1);
    chk("lat_vld_b_k", {31'd0, vld_b}, 32'd0);
    chk("lat_miso_b_k", miso_b, 32'd0);
    step();
    chk("mask_vld_a_off", {31'd0, vld_a}, 32'd0);
    chk("mask_miso_a_off", miso_a, 32'd0);
    chk("lat_vld_b_k1", {31'd0, vld_b}, 32'd1);
    chk("mask_rd_b", miso_b, 32'h11BB33DD);
    step();
    chk("lat_vld_b_k2", {31'd0, vld_b}, 32'd0);
    chk("lat_miso_b_k2", miso_b, 32'd0);

    $display("txn: full-mask collision on addr 3");
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hFFFFFFFF; wr_mask = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd3;
    step();
    chk("coll_old_a", miso_a, 32'h00000000);
    chk("coll_vld_a", {31'd0, vld_a}, 32'd1);
    $display("txn: half-mask collision on addr 3");
    wr_data = 32'h00000000; wr_mask = 4'h3;
    step();
    chk("coll2_old_a", miso_a, 32'hFFFFFFFF);
    chk("coll_new_b", miso_b, 32'hFFFFFFFF);
    $display("txn: write addr 7 with read addr 3");
    wr_addr = 4'd7; wr_data = 32'h12345678; wr_mask = 4'hF;
    step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("diff_rd_a", miso_a, 32'hFFFF0000);
    chk("coll2_new_b", miso_b, 32'hFFFF0000);
    step();
    chk("diff_rd_b", miso_b, 32'hFFFF0000);

    $display("txn: read addr 5 then clock enable low for 3 edges");
    rd_en = 1'b1; rd_addr = 4'd5;
    step();
    rd_en = 1'b1; rd_addr = 4'd3;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h0; wr_mask = 4'hF;
    en = 1'b0;
    chk("ce_rd_a", miso_a, 32'h11BB33DD);
    for (int n = 0; n < 3; n++) begin
      step();
      chk("ce_hold_a", miso_a, 32'h11BB33DD);
      chk("ce_hold_vld_a", {31'd0, vld_a}, 32'd1);
      chk("ce_hold_vld_b", {31'd0, vld_b}, 32'd0);
    end
    en = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    step();
    chk("ce_vld_a_off", {31'd0, vld_a}, 32'd0);
    chk("ce_rd_b", miso_b, 32'h11BB33DD);
    chk("ce_vld_b", {31'd0, vld_b}, 32'd1);
    rd_en = 1'b1; rd_addr = 4'd5;
    step();
    rd_en = 1'b0;
    chk("ce_nowr_a", miso_a, 32'h11BB33DD);

    $display("txn: write addr 9 then reset mid-sweep");
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'hDEADBEEF; wr_mask = 4'hF;
    step();
    wr_en = 1'b0; rd_en = 1'b1; rd_addr = 4'd9;
    step();
    rd_en = 1'b0;
    chk("pre_rst_rd_a", miso_a, 32'hDEADBEEF);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy_a", {31'd0, busy_a}, 32'd1);
    chk("async_rst_vld_a", {31'd0, vld_a}, 32'd0);
    step();
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'hCAFEF00D; wr_mask = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd9;
    for (int n = 0; n < 7; n++) step();
    chk("mid_busy_a", {31'd0, busy_a}, 32'd1);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    count_sweep();
    wr_en = 1'b0;
    rd_addr = 4'd0;
    step();
    chk("mid_rd0_a", miso_a, 32'd0);
    chk("mid_vld0_a", {31'd0, vld_a}, 32'd1);
    rd_addr = 4'd9;
    step();
    rd_en = 1'b0;
    chk("mid_rd9_a", miso_a, 32'd0);
    chk("mid_rd0_b", miso_b, 32'd0);
    chk("mid_vld0_b", {31'd0, vld_b}, 32'd1);
    step();
    chk("mid_rd9_b", miso_b, 32'd0);
    chk("mid_vld9_b", {31'd0, vld_b}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
